// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared types for the MIPS CPU slice.
//   IM_AW_DEFAULT   - default instruction-memory word-address width
//   im_addr_t       - instruction-memory word address at the default width
//   boot_state_enum - boot loader FSM states
package mips_cpu_pkg;

  localparam int IM_AW_DEFAULT = 10;

  typedef logic [IM_AW_DEFAULT-1:0] im_addr_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    RUN   = 3'd3,
    ERR   = 3'd4
  } boot_state_enum;

endpackage

// File: rtl/boot_loader.sv
// boot_loader: streams a program into instruction memory while the CPU core
// is held in reset, flushes the core for DRAIN_CYCLES cycles, then releases it.
//
// Ports
//   cpu_clk_50M  in   sole clock, rising edge
//   cpu_rst      in   synchronous active-high reset
//   load_start   in   single-cycle request to (re)start a program load
//   in_valid     in   in_inst/in_last valid
//   in_inst      in   instruction word
//   in_last      in   final word of the program (qualified by in_valid)
//   in_ready     out  loader accepts the word this cycle
//   imwe         out  instruction-memory write enable
//   imaddr       out  instruction-memory word address
//   imdin        out  instruction-memory write data
//   core_rst_n   out  active-low core reset, high only in RUN
//   done         out  program loaded, core running
//   err          out  program overflowed the instruction memory
//   word_cnt     out  words written in the current/last load
//   state        out  FSM state (debug)
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready are
// both 1. in_ready never depends on in_valid; upstream must hold the word
// stable while in_valid=1 and in_ready=0.
module boot_loader
  import mips_cpu_pkg::*;
#(
  parameter int IM_AW        = IM_AW_DEFAULT,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             load_start,
  input  logic             in_valid,
  input  logic [31:0]      in_inst,
  input  logic             in_last,
  output logic             in_ready,
  output logic             imwe,
  output logic [IM_AW-1:0] imaddr,
  output logic [31:0]      imdin,
  output logic             core_rst_n,
  output logic             done,
  output logic             err,
  output logic [IM_AW:0]   word_cnt,
  output boot_state_enum   state
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
  localparam logic [IM_AW-1:0] PTR_MAX = '1;

  boot_state_enum   state_d;
  logic [IM_AW-1:0] ptr, ptr_d;
  logic [DCW-1:0]   dcnt, dcnt_d;
  logic [IM_AW:0]   word_cnt_d;
  logic             imwe_d;
  logic [IM_AW-1:0] imaddr_d;
  logic [31:0]      imdin_d;
  logic             accept;

  // in_ready is registered as (state == LOAD), so it is the only qualifier needed.
  assign accept = in_valid & in_ready;

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    dcnt_d     = dcnt;
    word_cnt_d = word_cnt;
    imwe_d     = 1'b0;
    imaddr_d   = imaddr;
    imdin_d    = imdin;
    case (state)
      IDLE, RUN, ERR: begin
        if (load_start) begin
          state_d    = LOAD;
          ptr_d      = '0;
          word_cnt_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          imwe_d     = 1'b1;
          imaddr_d   = ptr;
          imdin_d    = in_inst;
          word_cnt_d = word_cnt + 1'b1;
          // The pointer saturates at the top word; a full memory either
          // finishes (in_last) or overflows into ERR, never wraps.
          if (ptr != PTR_MAX) ptr_d = ptr + 1'b1;
          if (in_last) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end else if (ptr == PTR_MAX) begin
            state_d = ERR;
          end
        end
      end
      DRAIN: begin
        if (dcnt == DRAIN_LAST) state_d = RUN;
        else                    dcnt_d  = dcnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state      <= IDLE;
      ptr        <= '0;
      dcnt       <= '0;
      word_cnt   <= '0;
      imwe       <= 1'b0;
      imaddr     <= '0;
      imdin      <= '0;
      in_ready   <= 1'b0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      dcnt       <= dcnt_d;
      word_cnt   <= word_cnt_d;
      imwe       <= imwe_d;
      imaddr     <= imaddr_d;
      imdin      <= imdin_d;
      in_ready   <= (state_d == LOAD);
      core_rst_n <= (state_d == RUN);
      done       <= (state_d == RUN);
      err        <= (state_d == ERR);
    end
  end

endmodule
